clz_unit: RTL and testbench

Multi-cycle count-leading-zeros / count-leading-ones unit for the MIPS32 core, serving the CLZ and CLO instructions. It runs the barrel-shifter datapath in the other direction: instead of applying a given shift amount, it derives the left-shift amount that normalizes an operand. It uses a 16/8/4/2/1 binary search, one stage per clock. It also returns the operand left-shifted by that amount, so the same block can feed normalization paths.

---
 rtl/clz_unit.sv | 100 ++++++++++
 tb/tb_clz_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/clz_unit.sv
// Multi-cycle count-leading-zeros/ones unit: 16/8/4/2/1 binary search, one stage
// per clock, returning the count and the operand normalized by that count.
module clz_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        Op,
  input  logic [31:0] Data,
  output logic        busy,
  output logic        done,
  output logic [5:0]  Count,
  output logic [31:0] Normalized
);

  // state  | meaning
  // IDLE   | waiting for start; done may still be pulsing from the last result
  // SEARCH | one binary-search stage per cycle, stage = 0..4 (width 16 >> stage)
  // FINISH | resolve all-ones/all-zeros case, register results and done
  typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

  state_t      state, state_nxt;
  logic [2:0]  stage, stage_nxt;
  logic [31:0] w_reg, w_nxt;
  logic [31:0] d_reg, d_nxt;
  logic [5:0]  c_reg, c_nxt;
  logic        done_nxt;
  logic [5:0]  count_nxt;
  logic [31:0] norm_nxt;
  logic [4:0]  step;
  logic [31:0] mask;
  logic        top_zero;

  assign step     = 5'd16 >> stage;
  assign mask     = ~(32'hFFFF_FFFF >> step);
  assign top_zero = (w_reg & mask) == 32'h0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      stage      <= 3'd0;
      w_reg      <= 32'h0;
      d_reg      <= 32'h0;
      c_reg      <= 6'd0;
      done       <= 1'b0;
      Count      <= 6'd0;
      Normalized <= 32'h0;
    end else begin
      state      <= state_nxt;
      stage      <= stage_nxt;
      w_reg      <= w_nxt;
      d_reg      <= d_nxt;
      c_reg      <= c_nxt;
      done       <= done_nxt;
      Count      <= count_nxt;
      Normalized <= norm_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    w_nxt     = w_reg;
    d_nxt     = d_reg;
    c_nxt     = c_reg;
    done_nxt  = 1'b0;
    count_nxt = Count;
    norm_nxt  = Normalized;
    case (state)
      IDLE: begin
        if (start) begin
          // CLO is searched as CLZ of the inverted operand; D keeps the true bits.
          w_nxt     = Op ? ~Data : Data;
          d_nxt     = Data;
          c_nxt     = 6'd0;
          stage_nxt = 3'd0;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (top_zero) begin
          c_nxt = c_reg + {1'b0, step};
          w_nxt = w_reg << step;
          d_nxt = d_reg << step;
        end
        if (stage == 3'd4) state_nxt = FINISH;
        else stage_nxt = stage + 3'd1;
      end
      FINISH: begin
        // W[31] clear here means the searched word was all zeros: count is 32.
        count_nxt = w_reg[31] ? c_reg : 6'd32;
        norm_nxt  = w_reg[31] ? d_reg : 32'h0;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clz_unit.sv
// Directed and swept checks of clz_unit against hand-computed values and a
// bit-serial leading-count reference.
module tb_clz_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        Op = 1'b0;
  logic [31:0] Data = 32'h0;
  logic        busy;
  logic        done;
  logic [5:0]  Count;
  logic [31:0] Normalized;

  int tests = 0;
  int fails = 0;

  clz_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Op(Op), .Data(Data),
    .busy(busy), .done(done), .Count(Count), .Normalized(Normalized)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_count(input logic op, input logic [31:0] d);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i] != op) break;
      n++;
    end
    return 6'(n);
  endfunction

  function automatic logic [31:0] ref_norm(input logic op, input logic [31:0] d);
    logic [5:0] n = ref_count(op, d);
    return (n == 6'd32) ? 32'h0 : (d << n);
  endfunction

  // Starts an operation, optionally re-pulses start at sample `glitch`, then
  // checks latency, busy length, busy/done exclusion, result and single pulse.
  task automatic run_op(input string tag, input logic op, input logic [31:0] data,
                        input logic [5:0] exp_c, input logic [31:0] exp_n,
                        input int glitch, input logic [31:0] gdata);
    int lat = 0;
    int busy_n = 0;
    int both = 0;
    @(negedge clk);
    Op = op; Data = data; start = 1'b1;
    @(negedge clk);
    start = 1'b0; Op = ~op; Data = ~data;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      start = (lat == glitch);
      if (lat == glitch) begin Data = gdata; Op = ~op; end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    if (busy && done) both++;
    chk({tag, "_latency"}, 32'(lat), 32'd6);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd6);
    chk({tag, "_busy_with_done"}, 32'(both), 32'd0);
    chk({tag, "_count"}, 32'(Count), 32'(exp_c));
    chk({tag, "_norm"}, Normalized, exp_n);
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_count_hold"}, 32'(Count), 32'(exp_c));
  endtask

  initial begin
    logic [31:0] v;
    logic        o;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_count", 32'(Count), 32'd0);
    chk("reset_norm", Normalized, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("clz_00010000", 1'b0, 32'h0001_0000, 6'd15, 32'h8000_0000, -1, 32'h0);
    run_op("clz_zero",     1'b0, 32'h0000_0000, 6'd32, 32'h0000_0000, -1, 32'h0);
    run_op("clz_msb",      1'b0, 32'h8000_0000, 6'd0,  32'h8000_0000, -1, 32'h0);
    run_op("clo_ffff0f00", 1'b1, 32'hFFFF_0F00, 6'd16, 32'h0F00_0000, -1, 32'h0);
    run_op("clo_ones",     1'b1, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, -1, 32'h0);
    run_op("clo_7fffffff", 1'b1, 32'h7FFF_FFFF, 6'd0,  32'h7FFF_FFFF, -1, 32'h0);
    run_op("clz_0000ffff", 1'b0, 32'h0000_FFFF, 6'd16, 32'hFFFF_0000, -1, 32'h0);
    run_op("clo_f0000001", 1'b1, 32'hF000_0001, 6'd4,  32'h0000_0010, -1, 32'h0);
    run_op("ignored_start", 1'b0, 32'h0001_0000, 6'd15, 32'h8000_0000, 2, 32'h0000_0001);

    // Abort mid-search: prior result (Count=15) must be wiped immediately.
    run_op("pre_reset", 1'b0, 32'h0001_0000, 6'd15, 32'h8000_0000, -1, 32'h0);
    @(negedge clk);
    Op = 1'b0; Data = 32'h0000_0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_count", 32'(Count), 32'd0);
    chk("abort_norm", Normalized, 32'h0);
    repeat (8) begin
      @(negedge clk);
      if (done) chk("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    run_op("post_reset_clz_1", 1'b0, 32'h0000_0001, 6'd31, 32'h8000_0000, -1, 32'h0);

    for (int i = 0; i < 32; i++) begin
      v = 32'h1 << i;
      run_op("onehot_clz", 1'b0, v, 6'(31 - i), 32'h8000_0000, -1, 32'h0);
      run_op("onecold_clo", 1'b1, ~v, 6'(31 - i), (i == 0) ? 32'h0 : ((~v) << (31 - i)), -1, 32'h0);
      run_op("onehot_clo", 1'b1, v, ref_count(1'b1, v), ref_norm(1'b1, v), -1, 32'h0);
      run_op("onecold_clz", 1'b0, ~v, ref_count(1'b0, ~v), ref_norm(1'b0, ~v), -1, 32'h0);
    end

    for (int i = 0; i < 2500; i++) begin
      v = $urandom;
      o = 1'($urandom_range(0, 1));
      // Bias toward long leading runs so large counts are exercised.
      if (i % 3 == 0) v = o ? ~(v >> $urandom_range(0, 31)) : (v >> $urandom_range(0, 31));
      run_op("random", o, v, ref_count(o, v), ref_norm(o, v), -1, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
